// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the program/data loader.
// Default geometry matches the CPU build this loader feeds.
package prog_loader_pkg;

   localparam int unsigned BYTE_W        = 8;
   localparam int unsigned INST_LEN_DEF  = 12;
   localparam int unsigned INST_CAP_DEF  = 20;
   localparam int unsigned IADDR_LEN_DEF = 5;
   localparam int unsigned DATA_LEN_DEF  = 8;
   localparam int unsigned ADDR_LEN_DEF  = 8;
   localparam int unsigned MEM_SIZE_DEF  = 256;

   // Instruction words arrive as a high byte carrying the top bits, then a low byte.
   localparam int unsigned INST_HI_W = INST_LEN_DEF - BYTE_W;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_INST_HI,
      ST_INST_LO,
      ST_DATA,
      ST_DONE
   } ld_state_e;

endpackage

// File: rtl/prog_loader_if.sv
// Host stream, memory write ports and CPU control of the loader.
// master = host/test side, slave = loader.
interface prog_loader_if
   import prog_loader_pkg::*;
#(
   parameter int unsigned INST_LEN  = INST_LEN_DEF,
   parameter int unsigned IADDR_LEN = IADDR_LEN_DEF,
   parameter int unsigned DATA_LEN  = DATA_LEN_DEF,
   parameter int unsigned ADDR_LEN  = ADDR_LEN_DEF
) ();

   logic                 start;
   logic [BYTE_W-1:0]    in_data;
   logic                 in_valid;
   logic                 in_ready;
   logic                 inst_we;
   logic [IADDR_LEN-1:0] inst_addr;
   logic [INST_LEN-1:0]  inst_wdata;
   logic                 mem_we;
   logic [ADDR_LEN-1:0]  mem_addr;
   logic [DATA_LEN-1:0]  mem_wdata;
   logic                 cpu_rstn;
   logic                 busy;
   logic                 done;

   modport master (
      output start, in_data, in_valid,
      input  in_ready, inst_we, inst_addr, inst_wdata, mem_we, mem_addr, mem_wdata,
             cpu_rstn, busy, done
   );

   modport slave (
      input  start, in_data, in_valid,
      output in_ready, inst_we, inst_addr, inst_wdata, mem_we, mem_addr, mem_wdata,
             cpu_rstn, busy, done
   );

endinterface

// File: rtl/prog_loader_ld_counter.sv
// Up-counter with synchronous clear, enable and a terminal flag at LIMIT-1.
// Terminal is a compare, so LIMIT == 2**WIDTH never relies on wrap-around.
module ld_counter #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned LIMIT = 256
) (
   input  logic             clk_i,
   input  logic             clr_i,
   input  logic             en_i,
   output logic [WIDTH-1:0] cnt_o,
   output logic             tc_o
);

   logic [WIDTH-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      cnt_q <= cnt_d;
   end

   assign cnt_o = cnt_q;
   assign tc_o  = (cnt_q == WIDTH'(LIMIT - 1));

endmodule

// File: rtl/prog_loader.sv
// Runtime loader: streams INST_CAP instruction words then MEM_SIZE data bytes
// into memory, holding the CPU in reset until the last byte is written.
module prog_loader
   import prog_loader_pkg::*;
#(
   parameter int unsigned INST_LEN  = INST_LEN_DEF,
   parameter int unsigned INST_CAP  = INST_CAP_DEF,
   parameter int unsigned IADDR_LEN = IADDR_LEN_DEF,
   parameter int unsigned DATA_LEN  = DATA_LEN_DEF,
   parameter int unsigned ADDR_LEN  = ADDR_LEN_DEF,
   parameter int unsigned MEM_SIZE  = MEM_SIZE_DEF
) (
   input  logic           clk,
   input  logic           rst,
   prog_loader_if.slave   bus
);

   localparam int unsigned HI_W = INST_LEN - BYTE_W;

   ld_state_e            state_q, state_d;
   logic [HI_W-1:0]      hi_q, hi_d;
   logic                 inst_we_q, inst_we_d;
   logic [IADDR_LEN-1:0] inst_addr_q, inst_addr_d;
   logic [INST_LEN-1:0]  inst_wdata_q, inst_wdata_d;
   logic                 mem_we_q, mem_we_d;
   logic [ADDR_LEN-1:0]  mem_addr_q, mem_addr_d;
   logic [DATA_LEN-1:0]  mem_wdata_q, mem_wdata_d;
   logic                 cpu_rstn_q, cpu_rstn_d;
   logic                 done_q, done_d;

   logic                 loading, accept, pend, restart;
   logic [IADDR_LEN-1:0] inst_idx;
   logic [ADDR_LEN-1:0]  data_idx;
   logic                 inst_tc, data_tc;

   assign loading = (state_q == ST_INST_HI) || (state_q == ST_INST_LO) || (state_q == ST_DATA);
   assign accept  = bus.in_valid & loading;
   assign pend    = inst_we_q | mem_we_q;
   // A final strobe still in flight counts as busy, so start is ignored until it retires.
   assign restart = bus.start & ~loading & ~pend;

   ld_counter #(.WIDTH(IADDR_LEN), .LIMIT(INST_CAP)) u_inst_cnt (
      .clk_i (clk),
      .clr_i (rst | restart),
      .en_i  (accept && (state_q == ST_INST_LO)),
      .cnt_o (inst_idx),
      .tc_o  (inst_tc)
   );

   ld_counter #(.WIDTH(ADDR_LEN), .LIMIT(MEM_SIZE)) u_data_cnt (
      .clk_i (clk),
      .clr_i (rst | restart),
      .en_i  (accept && (state_q == ST_DATA)),
      .cnt_o (data_idx),
      .tc_o  (data_tc)
   );

   always_comb begin
      state_d      = state_q;
      hi_d         = hi_q;
      inst_we_d    = 1'b0;
      inst_addr_d  = inst_addr_q;
      inst_wdata_d = inst_wdata_q;
      mem_we_d     = 1'b0;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      cpu_rstn_d   = cpu_rstn_q;
      done_d       = done_q;

      if (restart) begin
         state_d    = ST_INST_HI;
         cpu_rstn_d = 1'b0;
         done_d     = 1'b0;
      end

      case (state_q)
         ST_INST_HI: begin
            if (accept) begin
               hi_d    = bus.in_data[HI_W-1:0];
               state_d = ST_INST_LO;
            end
         end
         ST_INST_LO: begin
            if (accept) begin
               inst_we_d    = 1'b1;
               inst_addr_d  = inst_idx;
               inst_wdata_d = {hi_q, bus.in_data};
               state_d      = inst_tc ? ST_DATA : ST_INST_HI;
            end
         end
         ST_DATA: begin
            if (accept) begin
               mem_we_d    = 1'b1;
               mem_addr_d  = data_idx;
               mem_wdata_d = DATA_LEN'(bus.in_data);
               state_d     = data_tc ? ST_DONE : ST_DATA;
            end
         end
         ST_DONE: begin
            if (!restart) begin
               cpu_rstn_d = 1'b1;
               done_d     = 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         hi_q         <= '0;
         inst_we_q    <= 1'b0;
         inst_addr_q  <= '0;
         inst_wdata_q <= '0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         cpu_rstn_q   <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         hi_q         <= hi_d;
         inst_we_q    <= inst_we_d;
         inst_addr_q  <= inst_addr_d;
         inst_wdata_q <= inst_wdata_d;
         mem_we_q     <= mem_we_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         cpu_rstn_q   <= cpu_rstn_d;
         done_q       <= done_d;
      end
   end

   assign bus.in_ready   = loading;
   assign bus.busy       = loading | pend;
   assign bus.inst_we    = inst_we_q;
   assign bus.inst_addr  = inst_addr_q;
   assign bus.inst_wdata = inst_wdata_q;
   assign bus.mem_we     = mem_we_q;
   assign bus.mem_addr   = mem_addr_q;
   assign bus.mem_wdata  = mem_wdata_q;
   assign bus.cpu_rstn   = cpu_rstn_q;
   assign bus.done       = done_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: full, throttled, restart and abort loads.
module tb_prog_loader;
   import prog_loader_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;

   prog_loader_if bus ();

   prog_loader dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int unsigned n_err = 0;
   int unsigned n_chk = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int   iq_addr[$], iq_data[$], mq_addr[$], mq_data[$], str_cyc[$], acc_cyc[$];
   int   overlap = 0;
   int   last_mem_cyc = -1;
   int   done_rise_cyc = -1;
   logic done_prev = 1'b0;
   logic done_busy, done_rstn;

   always @(negedge clk) begin
      if (bus.inst_we) begin
         iq_addr.push_back(int'(bus.inst_addr));
         iq_data.push_back(int'(bus.inst_wdata));
         str_cyc.push_back(cyc);
      end
      if (bus.mem_we) begin
         mq_addr.push_back(int'(bus.mem_addr));
         mq_data.push_back(int'(bus.mem_wdata));
         str_cyc.push_back(cyc);
         last_mem_cyc = cyc;
      end
      if (bus.inst_we && bus.mem_we) overlap++;
      if (bus.done && !done_prev && done_rise_cyc < 0) begin
         done_rise_cyc = cyc;
         done_busy     = bus.busy;
         done_rstn     = bus.cpu_rstn;
      end
      done_prev = bus.done;
   end

   function automatic logic [11:0] inst_word(input int i);
      case (i)
         0:       return 12'hABC;
         1:       return 12'h5A5;
         default: return 12'(i * 211 + 291);
      endcase
   endfunction

   // Odd words carry junk in the unused upper nibble of the high byte (word 1 -> 0xF5).
   function automatic logic [7:0] hi_byte(input int i);
      logic [11:0] w;
      w = inst_word(i);
      return (i % 2 == 1) ? {4'hF, w[11:8]} : {4'h0, w[11:8]};
   endfunction

   function automatic logic [7:0] data_byte(input int j);
      return 8'(j * 7 + 3);
   endfunction

   task automatic send_byte(input logic [7:0] b, input int gap, input logic st, output int acc);
      logic r;
      acc = -1;
      r   = 1'b0;
      bus.in_valid = 1'b0;
      repeat (gap) begin
         @(posedge clk); #1;
      end
      bus.in_valid = 1'b1;
      bus.in_data  = b;
      bus.start    = st;
      for (int t = 0; t < 50; t++) begin
         r = bus.in_ready;
         @(posedge clk); #1;
         bus.start = 1'b0;
         if (r) begin
            acc = cyc;
            break;
         end
      end
      bus.in_valid = 1'b0;
      if (acc < 0) check_eq("send_ready_timeout", 32'(r), 32'd1);
   endtask

   task automatic do_load(input int gap_max, input int mid_start_at, input int rst_at, input string nm);
      int acc;
      int gap;
      int j_stop;
      j_stop = 256;
      iq_addr.delete(); iq_data.delete(); mq_addr.delete(); mq_data.delete();
      str_cyc.delete(); acc_cyc.delete();
      overlap = 0; last_mem_cyc = -1; done_rise_cyc = -1;

      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      check_eq({nm, "_start_cpu_rstn"}, 32'(bus.cpu_rstn), 32'd0);
      check_eq({nm, "_start_done"},     32'(bus.done),     32'd0);
      check_eq({nm, "_start_busy"},     32'(bus.busy),     32'd1);
      check_eq({nm, "_start_ready"},    32'(bus.in_ready), 32'd1);

      for (int i = 0; i < 20; i++) begin
         gap = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
         send_byte(hi_byte(i), gap, 1'b0, acc);
         gap = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
         send_byte(inst_word(i) & 12'hFF, gap, 1'b0, acc);
         acc_cyc.push_back(acc);
      end
      for (int j = 0; j < 256; j++) begin
         if (j == rst_at) begin
            bus.in_valid = 1'b1;
            bus.in_data  = data_byte(j);
            rst = 1'b1;
            @(posedge clk); #1;
            rst = 1'b0;
            bus.in_valid = 1'b0;
            j_stop = j;
            break;
         end
         gap = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
         send_byte(data_byte(j), gap, (j == mid_start_at), acc);
         acc_cyc.push_back(acc);
      end
      repeat (4) begin
         @(posedge clk); #1;
      end

      if (j_stop == 256) begin
         check_eq({nm, "_inst_count"}, iq_addr.size(), 32'd20);
         for (int i = 0; i < iq_addr.size() && i < 20; i++) begin
            check_eq($sformatf("%s_inst_addr[%0d]", nm, i), iq_addr[i], i);
            check_eq($sformatf("%s_inst_data[%0d]", nm, i), iq_data[i], 32'(inst_word(i)));
         end
         check_eq({nm, "_mem_count"}, mq_addr.size(), 32'd256);
         for (int j = 0; j < mq_addr.size() && j < 256; j++) begin
            check_eq($sformatf("%s_mem_addr[%0d]", nm, j), mq_addr[j], j);
            check_eq($sformatf("%s_mem_data[%0d]", nm, j), mq_data[j], 32'(data_byte(j)));
         end
         check_eq({nm, "_strobe_count"}, str_cyc.size(), acc_cyc.size());
         for (int k = 0; k < str_cyc.size() && k < acc_cyc.size(); k++)
            check_eq($sformatf("%s_latency[%0d]", nm, k), str_cyc[k], acc_cyc[k]);
         check_eq({nm, "_overlap"},       overlap,          32'd0);
         check_eq({nm, "_done_timing"},   done_rise_cyc,    last_mem_cyc + 1);
         check_eq({nm, "_done_busy"},     32'(done_busy),   32'd0);
         check_eq({nm, "_done_cpu_rstn"}, 32'(done_rstn),   32'd1);
         check_eq({nm, "_end_done"},      32'(bus.done),     32'd1);
         check_eq({nm, "_end_cpu_rstn"},  32'(bus.cpu_rstn), 32'd1);
         check_eq({nm, "_end_busy"},      32'(bus.busy),     32'd0);
         check_eq({nm, "_end_ready"},     32'(bus.in_ready), 32'd0);
      end else begin
         check_eq({nm, "_abort_mem_count"}, mq_addr.size(), j_stop);
         if (mq_addr.size() > 0)
            check_eq({nm, "_abort_last_addr"}, mq_addr[mq_addr.size()-1], j_stop - 1);
         check_eq({nm, "_abort_cpu_rstn"},  32'(bus.cpu_rstn), 32'd0);
         check_eq({nm, "_abort_busy"},      32'(bus.busy),     32'd0);
         check_eq({nm, "_abort_done"},      32'(bus.done),     32'd0);
         check_eq({nm, "_abort_ready"},     32'(bus.in_ready), 32'd0);
         check_eq({nm, "_abort_mem_addr"},  32'(bus.mem_addr), 32'd0);
         check_eq({nm, "_abort_inst_addr"}, 32'(bus.inst_addr), 32'd0);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, n_chk=%0d", n_chk);
      $fatal(1, "watchdog");
   end

   initial begin
      bus.start    = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
      rst = 1'b1;
      repeat (2) begin
         @(posedge clk); #1;
      end
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      @(negedge clk);
      check_eq("rst_in_ready",   32'(bus.in_ready),   32'd0);
      check_eq("rst_inst_we",    32'(bus.inst_we),    32'd0);
      check_eq("rst_inst_addr",  32'(bus.inst_addr),  32'd0);
      check_eq("rst_inst_wdata", 32'(bus.inst_wdata), 32'd0);
      check_eq("rst_mem_we",     32'(bus.mem_we),     32'd0);
      check_eq("rst_mem_addr",   32'(bus.mem_addr),   32'd0);
      check_eq("rst_mem_wdata",  32'(bus.mem_wdata),  32'd0);
      check_eq("rst_cpu_rstn",   32'(bus.cpu_rstn),   32'd0);
      check_eq("rst_busy",       32'(bus.busy),       32'd0);
      check_eq("rst_done",       32'(bus.done),       32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      check_eq("idle_in_ready", 32'(bus.in_ready), 32'd0);
      check_eq("idle_busy",     32'(bus.busy),     32'd0);

      do_load(0, -1, -1, "full");
      do_load(3, -1, -1, "thr");
      do_load(0, 50, -1, "mid");
      do_load(0, -1, -1, "reload");
      do_load(1, -1, 99, "rst");
      do_load(0, -1, -1, "after_rst");

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
